// File: rtl/gesture_pkg.sv
// Shared types and helpers for the tilt-gesture classifier.
// Gesture codes, FSM states and the saturating magnitude used by the candidate logic.
package gesture_pkg;

  localparam int AXIS_W = 16;

  typedef enum logic [2:0] {
    G_NONE  = 3'd0,
    G_LEFT  = 3'd1,
    G_RIGHT = 3'd2,
    G_UP    = 3'd3,
    G_DOWN  = 3'd4,
    G_PUSH  = 3'd5,
    G_PULL  = 3'd6
  } gesture_code_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_REPORT,
    ST_COOLDOWN
  } gesture_state_t;

  // |v| with the most negative value clamped to the largest positive one.
  function automatic logic [AXIS_W-1:0] abs_sat(input logic signed [AXIS_W-1:0] v);
    if (v == {1'b1, {(AXIS_W-1){1'b0}}})
      return {1'b0, {(AXIS_W-1){1'b1}}};
    else if (v[AXIS_W-1])
      return -v;
    else
      return v;
  endfunction

endpackage

// File: rtl/axis_avg.sv
// Power-of-two moving average for one signed axis.
// A running sum tracks the history window so each update costs one add and one subtract.
module axis_avg
  import gesture_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [AXIS_W-1:0] din,
  output logic signed [AXIS_W-1:0] dout
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = AXIS_W + AVG_LOG2;

  logic signed [AXIS_W-1:0] hist [DEPTH];
  logic signed [SUM_W-1:0]  sum;
  logic signed [SUM_W-1:0]  din_ext;
  logic signed [SUM_W-1:0]  old_ext;

  assign din_ext = din;
  assign old_ext = hist[DEPTH-1];

  // NOTE: the history is reset explicitly because early outputs average against zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else if (en) begin
      // NOTE: non-blocking so every history slot shifts from its pre-edge value.
      sum     <= sum + din_ext - old_ext;
      hist[0] <= din;
      for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
    end
  end

  // Arithmetic shift rounds toward minus infinity.
  assign dout = AXIS_W'(sum >>> AVG_LOG2);

endmodule

// File: rtl/gesture_detector.sv
// Sample capture, per-axis smoothing and a dwell/cooldown FSM that reports tilt gestures.
// Reports land two cycles after the accepting done_read edge.
module gesture_detector
  import gesture_pkg::*;
#(
  parameter logic [AXIS_W-1:0] THRESH   = 16'd4000,
  parameter int                AVG_LOG2 = 2,
  parameter int                DWELL    = 3,
  parameter int                COOLDOWN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     done_read,
  input  logic signed [AXIS_W-1:0] x_axis,
  input  logic signed [AXIS_W-1:0] y_axis,
  input  logic signed [AXIS_W-1:0] z_axis,
  output logic signed [AXIS_W-1:0] x_filt,
  output logic signed [AXIS_W-1:0] y_filt,
  output logic signed [AXIS_W-1:0] z_filt,
  output logic                     filt_valid,
  output logic                     gesture_valid,
  output logic [2:0]               gesture_code,
  output logic                     busy
);

  localparam int DW_W = $clog2(DWELL + 1);
  localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  logic done_read_q;
  logic armed;
  logic accept;

  // A done_read already high when reset releases must drop before it can count.
  assign accept = done_read & ~done_read_q & armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_read_q <= 1'b0;
      armed       <= 1'b0;
      filt_valid  <= 1'b0;
    end else begin
      done_read_q <= done_read;
      filt_valid  <= accept;
      if (!done_read) armed <= 1'b1;
    end
  end

  axis_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_x (.clk(clk), .rst(rst), .en(accept), .din(x_axis), .dout(x_filt));
  axis_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_y (.clk(clk), .rst(rst), .en(accept), .din(y_axis), .dout(y_filt));
  axis_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_z (.clk(clk), .rst(rst), .en(accept), .din(z_axis), .dout(z_filt));

  logic [AXIS_W-1:0] mag_x, mag_y, mag_z, best;
  gesture_code_t     cand;

  assign mag_x = abs_sat(x_filt);
  assign mag_y = abs_sat(y_filt);
  assign mag_z = abs_sat(z_filt);

  // Strict comparisons keep ties on the earlier axis.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    cand = G_NONE;
    best = '0;
    if (mag_x > THRESH) begin
      cand = x_filt[AXIS_W-1] ? G_LEFT : G_RIGHT;
      best = mag_x;
    end
    if (mag_y > THRESH && mag_y > best) begin
      cand = y_filt[AXIS_W-1] ? G_DOWN : G_UP;
      best = mag_y;
    end
    if (mag_z > THRESH && mag_z > best) begin
      cand = z_filt[AXIS_W-1] ? G_PULL : G_PUSH;
    end
  end

  gesture_state_t    state, state_n;
  gesture_code_t     code_q, code_n, code_out;
  logic [DW_W-1:0]   dwell, dwell_n, dwell_inc;
  logic [CD_W-1:0]   cd_cnt, cd_n;

  assign dwell_inc = (dwell == DW_W'(DWELL)) ? dwell : dwell + 1'b1;

  always_comb begin
    state_n = state;
    code_n  = code_q;
    dwell_n = dwell;
    cd_n    = cd_cnt;
    unique case (state)
      ST_IDLE: begin
        if (filt_valid && cand != G_NONE) begin
          code_n  = cand;
          dwell_n = DW_W'(1);
          state_n = (DWELL == 1) ? ST_REPORT : ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (filt_valid) begin
          if (cand == G_NONE) begin
            state_n = ST_IDLE;
          end else if (cand == code_q) begin
            dwell_n = dwell_inc;
            if (dwell_inc == DW_W'(DWELL)) state_n = ST_REPORT;
          end else begin
            code_n  = cand;
            dwell_n = DW_W'(1);
          end
        end
      end
      ST_REPORT: begin
        cd_n    = CD_W'(COOLDOWN);
        state_n = ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        if (filt_valid) begin
          if (cd_cnt != '0)        cd_n    = cd_cnt - 1'b1;
          else if (cand == G_NONE) state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      code_q   <= G_NONE;
      code_out <= G_NONE;
      dwell    <= '0;
      cd_cnt   <= '0;
    end else begin
      state  <= state_n;
      code_q <= code_n;
      dwell  <= dwell_n;
      cd_cnt <= cd_n;
      if (state_n == ST_REPORT) code_out <= code_n;
    end
  end

  assign gesture_valid = (state == ST_REPORT);
  assign gesture_code  = code_out;
  assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_gesture_detector.sv
// Directed bench for gesture_detector: filter values, gesture reports, cooldown and reset.
// Outputs are sampled on the falling edge, away from the active rising edge.
module tb_gesture_detector;

  logic               clk = 1'b0;
  logic               rst;
  logic               done_read;
  logic signed [15:0] x_axis, y_axis, z_axis;
  logic signed [15:0] x_filt, y_filt, z_filt;
  logic               filt_valid, gesture_valid, busy;
  logic [2:0]         gesture_code;

  gesture_detector #(
    .THRESH(16'd4000), .AVG_LOG2(2), .DWELL(3), .COOLDOWN(4)
  ) dut (
    .clk(clk), .rst(rst), .done_read(done_read),
    .x_axis(x_axis), .y_axis(y_axis), .z_axis(z_axis),
    .x_filt(x_filt), .y_filt(y_filt), .z_filt(z_filt),
    .filt_valid(filt_valid), .gesture_valid(gesture_valid),
    .gesture_code(gesture_code), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int pulse_cnt = 0;
  int fv_cnt = 0;

  always @(negedge clk) begin
    if (gesture_valid === 1'b1) pulse_cnt++;
    if (filt_valid === 1'b1) fv_cnt++;
  end

  logic               fv1, gv2, bz2;
  logic [2:0]         gc2;
  logic signed [15:0] fx, fy, fz;
  int                 snap;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One accept: filter result captured one cycle later, FSM result two cycles later.
  task automatic send(input logic signed [15:0] x, input logic signed [15:0] y, input logic signed [15:0] z);
    @(negedge clk);
    x_axis = x; y_axis = y; z_axis = z;
    done_read = 1'b1;
    @(negedge clk);
    done_read = 1'b0;
    fv1 = filt_valid; fx = x_filt; fy = y_filt; fz = z_filt;
    @(negedge clk);
    gv2 = gesture_valid; gc2 = gesture_code; bz2 = busy;
    repeat (7) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; done_read = 1'b0;
    x_axis = '0; y_axis = '0; z_axis = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; done_read = 1'b0;
    x_axis = '0; y_axis = '0; z_axis = '0;
    @(negedge clk);
    check("rst_x_filt", x_filt, 0);
    check("rst_y_filt", y_filt, 0);
    check("rst_z_filt", z_filt, 0);
    check("rst_filt_valid", filt_valid, 0);
    check("rst_gesture_valid", gesture_valid, 0);
    check("rst_gesture_code", gesture_code, 0);
    check("rst_busy", busy, 0);

    // done_read pulse during reset, then held high across reset release
    snap = fv_cnt;
    x_axis = 16'sd8000;
    done_read = 1'b1;
    @(negedge clk);
    done_read = 1'b0;
    @(negedge clk);
    done_read = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    done_read = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_no_filt_valid", fv_cnt - snap, 0);
    check("rst_release_x_filt", x_filt, 0);

    // X = +8000 run: RIGHT after the 5th accept
    snap = pulse_cnt;
    send(16'sd8000, 0, 0);
    check("r1_fv", fv1, 1); check("r1_xf", fx, 2000); check("r1_gv", gv2, 0);
    send(16'sd8000, 0, 0);
    check("r2_xf", fx, 4000); check("r2_gv", gv2, 0); check("r2_busy", bz2, 0);
    send(16'sd8000, 0, 0);
    check("r3_xf", fx, 6000); check("r3_gv", gv2, 0); check("r3_busy", bz2, 1);
    send(16'sd8000, 0, 0);
    check("r4_xf", fx, 8000); check("r4_gv", gv2, 0);
    send(16'sd8000, 0, 0);
    check("r5_gv", gv2, 1); check("r5_code", gc2, 2);
    check("r_single_pulse", pulse_cnt - snap, 1);

    // hold X: cooldown expires but release is required
    snap = pulse_cnt;
    repeat (6) send(16'sd8000, 0, 0);
    check("hold_no_pulse", pulse_cnt - snap, 0);
    check("hold_busy", bz2, 1);
    check("hold_code_kept", gesture_code, 2);

    send(0, 0, 0);
    check("rel1_xf", fx, 6000); check("rel1_busy", bz2, 1);
    send(0, 0, 0);
    check("rel2_xf", fx, 4000); check("rel2_busy", bz2, 0);
    send(0, 0, 0);
    send(0, 0, 0);
    check("rel4_xf", fx, 0);

    // X = -8000 run: LEFT
    snap = pulse_cnt;
    send(-16'sd8000, 0, 0);
    check("l1_xf", fx, -2000);
    send(-16'sd8000, 0, 0);
    check("l2_busy_at_4000", bz2, 0);
    send(-16'sd8000, 0, 0);
    send(-16'sd8000, 0, 0);
    check("l4_gv", gv2, 0);
    send(-16'sd8000, 0, 0);
    check("l5_gv", gv2, 1); check("l5_code", gc2, 1);
    check("l_single_pulse", pulse_cnt - snap, 1);

    // Y = -12000: DOWN after the 4th accept
    do_reset();
    check("y_rst_code", gesture_code, 0);
    snap = pulse_cnt;
    send(0, -16'sd12000, 0);
    check("d1_yf", fy, -3000);
    send(0, -16'sd12000, 0);
    check("d2_yf", fy, -6000); check("d2_gv", gv2, 0);
    send(0, -16'sd12000, 0);
    check("d3_gv", gv2, 0);
    send(0, -16'sd12000, 0);
    check("d4_yf", fy, -12000); check("d4_gv", gv2, 1); check("d4_code", gc2, 4);
    repeat (20) @(negedge clk);
    check("d_single_pulse", pulse_cnt - snap, 1);

    // tie X=+8000 / Y=-8000 goes to X
    do_reset();
    repeat (4) send(16'sd8000, -16'sd8000, 0);
    check("tie_xf", fx, 8000); check("tie_yf", fy, -8000);
    send(16'sd8000, -16'sd8000, 0);
    check("tie_gv", gv2, 1); check("tie_code", gc2, 2);

    // Z = -32768: saturated magnitude, PULL after the 3rd accept
    do_reset();
    send(0, 0, -16'sh8000);
    check("z1_zf", fz, -8192);
    send(0, 0, -16'sh8000);
    send(0, 0, -16'sh8000);
    check("z3_gv", gv2, 1); check("z3_code", gc2, 6);
    send(0, 0, -16'sh8000);
    check("z4_zf", fz, -32768);

    // floor rounding of a small negative sum
    do_reset();
    send(-16'sd1, 16'sd5, 0);
    check("floor_xf", fx, -1);
    check("floor_yf", fy, 1);

    // done_read held for 5 cycles is a single sample; reset mid-TRACK
    do_reset();
    snap = fv_cnt;
    @(negedge clk);
    x_axis = 16'sd8000; y_axis = '0; z_axis = '0;
    done_read = 1'b1;
    repeat (5) @(negedge clk);
    done_read = 1'b0;
    repeat (5) @(negedge clk);
    check("held_one_fv", fv_cnt - snap, 1);
    check("held_xf", x_filt, 2000);
    send(16'sd8000, 0, 0);
    send(16'sd8000, 0, 0);
    check("trk_busy", bz2, 1);
    snap = pulse_cnt;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("trk_rst_busy", busy, 0);
    check("trk_rst_xf", x_filt, 0);
    check("trk_rst_gv", gesture_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("trk_no_pulse", pulse_cnt - snap, 0);
    check("trk_post_xf", x_filt, 0);
    check("trk_post_code", gesture_code, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
